// File: rtl/cam_capture_rgb444.sv
// Camera capture: pairs OV7670 bytes into RGB444 pixels and writes them into the frame buffer window.
// Latency: the write pulse (regW/addr/data) is registered; it appears the cycle after the second byte is sampled.
// Backpressure: none; the camera cannot be stalled, so pixels outside the window are dropped rather than held.
module cam_capture_rgb444 #(
    parameter int AW     = 15,
    parameter int DW     = 12,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ROW_IDLE   = 2'd1,
        BYTE1      = 2'd2,
        BYTE2      = 2'd3
    } state_t;

    localparam logic [8:0]    WIDTH_C  = 9'(WIDTH);
    localparam logic [8:0]    HEIGHT_C = 9'(HEIGHT);
    localparam logic [AW-1:0] WIDTH_A  = AW'(WIDTH);

    state_t        state, state_n;
    logic          vsync_d;
    logic [8:0]    row, row_n;
    logic [8:0]    col, col_n;
    logic [AW-1:0] line_base, line_base_n;
    logic [3:0]    r_lat, r_lat_n;
    logic          wrote, wrote_n;
    logic          regw_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] data_n;
    logic          frame_done_n;
    logic          end_line;

    // State register; reset parks the FSM until a fresh vsync falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath decode: byte pairing, window clipping, line/frame bookkeeping.
    always_comb begin
        state_n      = state;
        row_n        = row;
        col_n        = col;
        line_base_n  = line_base;
        r_lat_n      = r_lat;
        wrote_n      = wrote;
        regw_n       = 1'b0;
        addr_n       = DP_RAM_addr_in;
        data_n       = DP_RAM_data_in;
        frame_done_n = 1'b0;
        end_line     = 1'b0;

        if (state == WAIT_FRAME) begin
            // Only a clean vsync fall opens a frame, so a reset mid-frame never resumes a partial one.
            if (vsync_d && !CAM_vsync) begin
                row_n       = 9'd0;
                col_n       = 9'd0;
                line_base_n = '0;
                wrote_n     = 1'b0;
                state_n     = ROW_IDLE;
            end
        end else if (CAM_vsync) begin
            // vsync wins over href: any half-assembled pixel is discarded.
            state_n      = WAIT_FRAME;
            frame_done_n = wrote;
        end else begin
            unique case (state)
                ROW_IDLE: begin
                    if (CAM_href) begin
                        r_lat_n = CAM_px_data[3:0];
                        state_n = BYTE2;
                    end
                end
                BYTE1: begin
                    if (CAM_href) begin
                        r_lat_n = CAM_px_data[3:0];
                        state_n = BYTE2;
                    end else begin
                        end_line = 1'b1;
                    end
                end
                BYTE2: begin
                    if (CAM_href) begin
                        if ((col < WIDTH_C) && (row < HEIGHT_C)) begin
                            regw_n  = 1'b1;
                            addr_n  = line_base + {{(AW-9){1'b0}}, col};
                            data_n  = DW'({r_lat, CAM_px_data});
                            wrote_n = 1'b1;
                        end
                        if (col < WIDTH_C) begin
                            col_n = col + 9'd1;
                        end
                        state_n = BYTE1;
                    end else begin
                        // A lone first byte at the end of an odd-length line is dropped here.
                        end_line = 1'b1;
                    end
                end
                default: begin
                    state_n = WAIT_FRAME;
                end
            endcase
        end

        // Empty lines do not advance the row; row and line_base stop at the bottom of the window.
        if (end_line) begin
            if ((col != 9'd0) && (row < HEIGHT_C)) begin
                row_n       = row + 9'd1;
                line_base_n = line_base + WIDTH_A;
            end
            col_n   = 9'd0;
            state_n = ROW_IDLE;
        end
    end

    // Datapath and output registers; addr/data hold their last value between write pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d        <= 1'b0;
            row            <= 9'd0;
            col            <= 9'd0;
            line_base      <= '0;
            r_lat          <= 4'd0;
            wrote          <= 1'b0;
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
            frame_done     <= 1'b0;
        end else begin
            vsync_d        <= CAM_vsync;
            row            <= row_n;
            col            <= col_n;
            line_base      <= line_base_n;
            r_lat          <= r_lat_n;
            wrote          <= wrote_n;
            DP_RAM_regW    <= regw_n;
            DP_RAM_addr_in <= addr_n;
            DP_RAM_data_in <= data_n;
            frame_done     <= frame_done_n;
        end
    end

endmodule
